// File: rtl/ipark_tr.sv
// ----------------------------------------------------------------------------
// ipark_tr -- inverse Park transform (d/q -> alpha/beta)
//
//   valpha = vd*cos - vq*sin
//   vbeta  = vd*sin + vq*cos
//
// A single signed DW x DW multiplier is time-shared over four cycles under an
// FSM (IDLE -> MA0 -> MA1 -> MB0 -> MB1 -> FIN -> IDLE). sin/cos are signed
// fixed point with FRAC fractional bits (Q14 at default: 16384 = 1.0).
// Results are rounded half toward +inf, then saturated to DW bits.
//
// Handshake: i_en is a one-cycle "operands valid" strobe that is only looked
// at while the block is idle (o_busy = 0). While busy, i_en is dropped and the
// captured operands stay untouched. o_en pulses high for exactly one cycle
// when o_valpha/o_vbeta take a new value; the outputs hold between updates.
//
// Optional feature macro: IPARK_OVERRUN_EN
//   defined   -> o_overrun port exists; sticky flag set by i_en while busy,
//                cleared only by reset.
//   undefined -> no o_overrun port; i_en while busy is silently dropped.
//
// Ports
//   clk        in   1   clock, rising edge
//   rstn       in   1   asynchronous active-low reset
//   i_en       in   1   input-valid strobe (sampled only when idle)
//   i_vd       in   DW  d-axis voltage, signed
//   i_vq       in   DW  q-axis voltage, signed
//   i_sin      in   DW  sin(psi), signed fixed point
//   i_cos      in   DW  cos(psi), signed fixed point
//   o_en       out  1   one-cycle result strobe
//   o_valpha   out  DW  alpha-axis voltage, signed
//   o_vbeta    out  DW  beta-axis voltage, signed
//   o_busy     out  1   transform in progress
//   o_overrun  out  1   sticky overrun flag (IPARK_OVERRUN_EN only)
// ----------------------------------------------------------------------------
module ipark_tr #(
    parameter int DW   = 16,
    parameter int FRAC = 14
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_vd,
    input  logic signed [DW-1:0] i_vq,
    input  logic signed [DW-1:0] i_sin,
    input  logic signed [DW-1:0] i_cos,
    output logic                 o_en,
    output logic signed [DW-1:0] o_valpha,
    output logic signed [DW-1:0] o_vbeta,
    output logic                 o_busy
`ifdef IPARK_OVERRUN_EN
    ,
    output logic                 o_overrun
`endif
);

    localparam int PW = 2 * DW;      // product width
    localparam int AW = 2 * DW + 1;  // accumulator width: sum of two products cannot overflow
    localparam int RW = AW + 1;      // headroom for the rounding constant

    localparam logic signed [RW-1:0] RND_C = RW'(1) <<< (FRAC - 1);
    localparam logic signed [RW-1:0] MAX_C = RW'((2 ** (DW - 1)) - 1);
    localparam logic signed [RW-1:0] MIN_C = ~MAX_C;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MA0  = 3'd1,
        MA1  = 3'd2,
        MB0  = 3'd3,
        MB1  = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [DW-1:0] vd_r;
    logic signed [DW-1:0] vq_r;
    logic signed [DW-1:0] sin_r;
    logic signed [DW-1:0] cos_r;

    logic signed [DW-1:0] mul_x;
    logic signed [DW-1:0] mul_y;
    logic signed [PW-1:0] prod;

    logic signed [AW-1:0] acc_a;
    logic signed [AW-1:0] acc_b;
    logic signed [RW-1:0] rnd_a;
    logic signed [RW-1:0] rnd_b;

    function automatic logic signed [DW-1:0] sat(input logic signed [RW-1:0] x);
        if (x > MAX_C) begin
            return DW'(MAX_C);
        end else if (x < MIN_C) begin
            return DW'(MIN_C);
        end
        return DW'(x);
    endfunction

    // The one shared multiplier.
    assign prod = PW'(mul_x) * PW'(mul_y);

    // Round half toward +inf: add half an LSB, then arithmetic shift.
    assign rnd_a = (RW'(acc_a) + RND_C) >>> FRAC;
    assign rnd_b = (RW'(acc_b) + RND_C) >>> FRAC;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and multiplier operand selection.
    always_comb begin
        state_nxt = state;
        mul_x     = '0;
        mul_y     = '0;
        case (state)
            IDLE: begin
                if (i_en) begin
                    state_nxt = MA0;
                end
            end
            MA0: begin
                mul_x     = vd_r;
                mul_y     = cos_r;
                state_nxt = MA1;
            end
            MA1: begin
                mul_x     = vq_r;
                mul_y     = sin_r;
                state_nxt = MB0;
            end
            MB0: begin
                mul_x     = vd_r;
                mul_y     = sin_r;
                state_nxt = MB1;
            end
            MB1: begin
                mul_x     = vq_r;
                mul_y     = cos_r;
                state_nxt = FIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vd_r     <= '0;
            vq_r     <= '0;
            sin_r    <= '0;
            cos_r    <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            o_valpha <= '0;
            o_vbeta  <= '0;
            o_en     <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_en) begin
                        vd_r   <= i_vd;
                        vq_r   <= i_vq;
                        sin_r  <= i_sin;
                        cos_r  <= i_cos;
                        o_busy <= 1'b1;
                    end
                end
                MA0: acc_a <= AW'(prod);
                MA1: acc_a <= acc_a - AW'(prod);
                MB0: acc_b <= AW'(prod);
                MB1: acc_b <= acc_b + AW'(prod);
                FIN: begin
                    o_valpha <= sat(rnd_a);
                    o_vbeta  <= sat(rnd_b);
                    o_en     <= 1'b1;
                    o_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef IPARK_OVERRUN_EN
    // Any strobe that arrives while busy is lost; remember that it happened.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_overrun <= 1'b0;
        end else if (i_en && o_busy) begin
            o_overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ipark_tr.sv
// ----------------------------------------------------------------------------
// tb_ipark_tr -- self-checking bench for ipark_tr.
// A behavioural reference (plain integer arithmetic, countdown of busy time)
// predicts every output each cycle; directed vectors pin it with literals.
// ----------------------------------------------------------------------------
module tb_ipark_tr;

    localparam int DW = 16;

    logic                 clk;
    logic                 rstn;
    logic                 i_en;
    logic signed [DW-1:0] i_vd;
    logic signed [DW-1:0] i_vq;
    logic signed [DW-1:0] i_sin;
    logic signed [DW-1:0] i_cos;
    logic                 o_en;
    logic signed [DW-1:0] o_valpha;
    logic signed [DW-1:0] o_vbeta;
    logic                 o_busy;
`ifdef IPARK_OVERRUN_EN
    logic                 o_overrun;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int en_count = 0;

    ipark_tr #(.DW(DW), .FRAC(14)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_en     (i_en),
        .i_vd     (i_vd),
        .i_vq     (i_vq),
        .i_sin    (i_sin),
        .i_cos    (i_cos),
        .o_en     (o_en),
        .o_valpha (o_valpha),
        .o_vbeta  (o_vbeta),
        .o_busy   (o_busy)
`ifdef IPARK_OVERRUN_EN
        ,
        .o_overrun(o_overrun)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sat16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // floor((x + 8192) / 16384) for signed x
    function automatic longint rnd14(input longint x);
        return (x + 8192) >>> 14;
    endfunction

    longint exp_a    = 0;
    longint exp_b    = 0;
    logic   exp_en   = 1'b0;
    logic   exp_busy = 1'b0;
    logic   exp_ovr  = 1'b0;
    int     remain   = 0;      // cycles until the in-flight result appears
    longint pend_a   = 0;
    longint pend_b   = 0;

    always @(posedge clk) begin
        if (!rstn) begin
            exp_a    = 0;
            exp_b    = 0;
            exp_en   = 1'b0;
            exp_busy = 1'b0;
            exp_ovr  = 1'b0;
            remain   = 0;
        end else begin
            exp_en = 1'b0;
            if (remain > 0) begin
                if (i_en) exp_ovr = 1'b1;
                remain--;
                if (remain == 0) begin
                    exp_a    = pend_a;
                    exp_b    = pend_b;
                    exp_en   = 1'b1;
                    exp_busy = 1'b0;
                end
            end else if (i_en) begin
                pend_a   = sat16(rnd14(longint'(i_vd) * longint'(i_cos) - longint'(i_vq) * longint'(i_sin)));
                pend_b   = sat16(rnd14(longint'(i_vd) * longint'(i_sin) + longint'(i_vq) * longint'(i_cos)));
                remain   = 5;
                exp_busy = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #2;
        chk("cyc_en",     longint'(o_en),     longint'(exp_en));
        chk("cyc_busy",   longint'(o_busy),   longint'(exp_busy));
        chk("cyc_valpha", longint'(o_valpha), exp_a);
        chk("cyc_vbeta",  longint'(o_vbeta),  exp_b);
`ifdef IPARK_OVERRUN_EN
        chk("cyc_overrun", longint'(o_overrun), longint'(exp_ovr));
`endif
        if (o_en) en_count++;
    end

    // ---------------- driver tasks ----------------
    task automatic set_ops(input int vd, input int vq, input int s, input int c);
        i_vd  = DW'(vd);
        i_vq  = DW'(vq);
        i_sin = DW'(s);
        i_cos = DW'(c);
    endtask

    // One-pulse transform with literal expectations on result, latency and busy time.
    task automatic run_vec(input string name, input int vd, input int vq, input int s,
                           input int c, input int ea, input int eb);
        int k;
        int busy_cycles;
        logic got;
        @(negedge clk);
        set_ops(vd, vq, s, c);
        i_en = 1'b1;
        got = 1'b0;
        busy_cycles = 0;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #3;
            i_en = 1'b0;
            if (o_busy) busy_cycles++;
            if (o_en) begin
                k = i;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no o_en within 10 cycles", name);
        end else begin
            chk({name, "_valpha"},  longint'(o_valpha), longint'(ea));
            chk({name, "_vbeta"},   longint'(o_vbeta),  longint'(eb));
            chk({name, "_latency"}, longint'(k),        6);
            chk({name, "_busy"},    longint'(busy_cycles), 5);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_en",     longint'(o_en),     0);
        chk("rst_busy",   longint'(o_busy),   0);
        chk("rst_valpha", longint'(o_valpha), 0);
        chk("rst_vbeta",  longint'(o_vbeta),  0);
`ifdef IPARK_OVERRUN_EN
        chk("rst_overrun", longint'(o_overrun), 0);
`endif
        repeat (cycles) @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        rstn = 1'b1;
        i_en = 1'b0;
        set_ops(0, 0, 0, 0);
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_valpha", longint'(o_valpha), 0);
        chk("init_vbeta",  longint'(o_vbeta),  0);
        chk("init_busy",   longint'(o_busy),   0);
        chk("init_en",     longint'(o_en),     0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // directed, hand-computed
        run_vec("t1",    1000,    0,     0, 16384,   1000,     0);
        run_vec("t2",    1000,  500, 16384,     0,   -500,  1000);
        run_vec("t3a",  32767, 32767, 16384, 16384,     0, 32767);
        run_vec("t3b", -32768, 32767, 16384, 16384, -32768,   -1);
        run_vec("t4a",      3,    0,     0,  8192,      2,     0);
        run_vec("t4b",     -3,    0,     0,  8192,     -1,     0);

        // i_en held high for 20 cycles with changing data
        c0 = en_count;
        @(negedge clk);
        i_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_ops(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
            @(negedge clk);
        end
        i_en = 1'b0;
        repeat (8) @(negedge clk);
        chk("held_pulses", longint'(en_count - c0), 4);
`ifdef IPARK_OVERRUN_EN
        chk("held_overrun", longint'(o_overrun), 1);
`endif

        // reset two cycles into a transform
        @(negedge clk);
        set_ops(1000, 0, 0, 16384);
        i_en = 1'b1;
        @(negedge clk);
        i_en = 1'b0;
        @(negedge clk);
        c0 = en_count;
        do_reset(1);
        repeat (8) @(negedge clk);
        chk("abort_no_en", longint'(en_count - c0), 0);
        run_vec("t6", 1000, 500, 16384, 0, -500, 1000);

        // random traffic, including overlaps and extreme operands
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            i_en = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                set_ops(($urandom_range(0, 1) != 0) ? 32767 : -32768,
                        ($urandom_range(0, 1) != 0) ? 32767 : -32768,
                        ($urandom_range(0, 1) != 0) ? 16384 : -16384,
                        ($urandom_range(0, 1) != 0) ? 16384 : -16384);
            end else begin
                set_ops(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                        int'($urandom_range(0, 32768)) - 16384,
                        int'($urandom_range(0, 32768)) - 16384);
            end
        end
        @(negedge clk);
        i_en = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
